multicycle_controller: RTL

Sequencing control unit that drives a multicycle RV32I-subset datapath built from the existing register file, ALU, extender and mux blocks. Each instruction takes several clock cycles through a Moore FSM, so one ALU and one unified instruction/data memory port are shared across cycles. A ready handshake on the memory port stretches fetch and data-access states until memory responds. Supported instructions are lw, sw, R-type ALU (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq and jal. Any other opcode traps.

---
 rtl/riscv_ctrl_pkg.sv | 142 ++++++++++++++
 rtl/alu_dec.sv | 31 +++
 rtl/multicycle_controller.sv | 95 +++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Registered control word; fetch and branch mark the two states whose
   // PC/IR enables are qualified by mem_ready or Zero at the output.
   typedef struct packed {
      logic       fetch;
      logic       branch;
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] imm_src;
      alu_op_t    alu_op;
   } ctrl_t;

   // Control word for a given state; op only matters for the lw/sw
   // immediate format chosen in MEMADR.
   function automatic ctrl_t state_ctrl(state_t s, logic [6:0] opc);
      ctrl_t c;
      c        = '0;
      c.alu_op = ALUOP_ADD;
      case (s)
         S_FETCH: begin
            c.fetch      = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURESULT;
         end
         S_DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.imm_src   = IMM_B;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.imm_src   = (opc == OP_SW) ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = 1'b1;
            c.mem_write  = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_WD;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXECI: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.imm_src   = IMM_I;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a  = SRCA_RD1;
            c.alu_src_b  = SRCB_WD;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
         end
         S_JAL: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALUOUT;
            c.pc_write   = 1'b1;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: maps ALUOp plus instruction fields to ALUControl.
module alu_dec
   import riscv_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   // Subtract only for R-type funct3=000 with funct7b5 set; addi ignores bit 30
   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I-subset datapath with a shared
// memory port stretched by mem_ready.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       illegal
);

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;
   logic   illegal_q;

   function automatic state_t next_state(state_t s, logic [6:0] opc, logic ready);
      state_t n;
      n = S_FETCH;
      case (s)
         S_FETCH:    n = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opc)
               OP_LW, OP_SW: n = S_MEMADR;
               OP_RTYPE:     n = S_EXECR;
               OP_ITYPE:     n = S_EXECI;
               OP_BEQ:       n = S_BEQ;
               OP_JAL:       n = S_JAL;
               default:      n = S_TRAP;
            endcase
         end
         S_MEMADR:   n = (opc == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  n = ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    n = S_FETCH;
         S_MEMWRITE: n = ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:    n = S_ALUWB;
         S_EXECI:    n = S_ALUWB;
         S_ALUWB:    n = S_FETCH;
         S_BEQ:      n = S_FETCH;
         S_JAL:      n = S_ALUWB;
         S_TRAP:     n = S_TRAP;
         default:    n = S_FETCH;
      endcase
      return n;
   endfunction

   assign state_next = next_state(state, op, mem_ready);

   // State and its decoded control word are registered together so outputs come straight from flops
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_FETCH;
         ctrl      <= state_ctrl(S_FETCH, op);
         illegal_q <= 1'b0;
      end else begin
         state     <= state_next;
         ctrl      <= state_ctrl(state_next, op);
         illegal_q <= (state_next == S_TRAP);
      end
   end

   assign PCWrite    = rst & (ctrl.pc_write | (ctrl.fetch & mem_ready) | (ctrl.branch & Zero));
   assign IRWrite    = rst & ctrl.fetch & mem_ready;
   assign MemWrite   = rst & ctrl.mem_write;
   assign RegWrite   = rst & ctrl.reg_write;
   assign AdrSrc     = ctrl.adr_src;
   assign ResultSrc  = ctrl.result_src;
   assign ALUSrcA    = ctrl.alu_src_a;
   assign ALUSrcB    = ctrl.alu_src_b;
   assign ImmSrc     = ctrl.imm_src;
   assign illegal    = illegal_q;

   alu_dec u_alu_dec (
      .alu_op      (ctrl.alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (ALUControl)
   );

endmodule
